// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer that lets two requesters share one ALU:
// it latches the winner's operands, waits for the ALU to settle, then returns the result with a DONE pulse.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int SEL_WIDTH     = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ0,
  input  logic [SEL_WIDTH-1:0]  SEL0,
  input  logic [DATA_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] B0,
  input  logic                  REQ1,
  input  logic [SEL_WIDTH-1:0]  SEL1,
  input  logic [DATA_WIDTH-1:0] A1,
  input  logic [DATA_WIDTH-1:0] B1,
  output logic [DATA_WIDTH-1:0] ALU_DATA1,
  output logic [DATA_WIDTH-1:0] ALU_DATA2,
  output logic [SEL_WIDTH-1:0]  ALU_SELECT,
  input  logic [DATA_WIDTH-1:0] ALU_RESULT,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  ZERO,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  gnt_q;
  logic                  lastGnt_q;
  logic [DATA_WIDTH-1:0] aluData1_q;
  logic [DATA_WIDTH-1:0] aluData2_q;
  logic [SEL_WIDTH-1:0]  aluSelect_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  done0_q;
  logic                  done1_q;
  logic                  busy_q;

  logic                  anyReq;
  logic                  gnt_d;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    anyReq = REQ0 | REQ1;
    gnt_d  = 1'b0;
    if (REQ0 && REQ1) begin
      gnt_d = ~lastGnt_q;
    end else if (REQ1) begin
      gnt_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      gnt_q       <= 1'b0;
      lastGnt_q   <= 1'b1;
      aluData1_q  <= '0;
      aluData2_q  <= '0;
      aluSelect_q <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (anyReq) begin
            gnt_q       <= gnt_d;
            lastGnt_q   <= gnt_d;
            aluData1_q  <= gnt_d ? A1 : A0;
            aluData2_q  <= gnt_d ? B1 : B0;
            aluSelect_q <= gnt_d ? SEL1 : SEL0;
            cnt_q       <= SETTLE_INIT;
            busy_q      <= 1'b1;
            state_q     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_q - 4'd1;
          // The ALU output is only trusted on the last settle edge.
          if (cnt_q == 4'd1) begin
            result_q <= ALU_RESULT;
            zero_q   <= (ALU_RESULT == '0);
            done0_q  <= ~gnt_q;
            done1_q  <= gnt_q;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ALU_DATA1  = aluData1_q;
  assign ALU_DATA2  = aluData2_q;
  assign ALU_SELECT = aluSelect_q;
  assign RESULT     = result_q;
  assign ZERO       = zero_q;
  assign DONE0      = done0_q;
  assign DONE1      = done1_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with an instant ALU (settle 1)
// and one with settle 3 driving a two-cycle-delayed ALU model.
module tb_alu_share_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       req0, req1;
  logic [2:0] sel0, sel1;
  logic [7:0] a0, b0, a1, b1;
  logic [7:0] aluData1, aluData2, aluResult, result;
  logic [2:0] aluSelect;
  logic       zero, done0, done1, busy;

  logic       reqB;
  logic [2:0] selB;
  logic [7:0] aB, bB;
  logic       zeroBit = 1'b0;
  logic [2:0] zeroSel = 3'd0;
  logic [7:0] zeroByte = 8'd0;
  logic [7:0] aluData1B, aluData2B, aluResultB, resultB;
  logic [2:0] aluSelectB;
  logic       zeroB, done0B, done1B, busyB;
  logic [7:0] delay1B, delay2B;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  function automatic logic [7:0] aluModel(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      3'd0: aluModel = x + y;
      3'd1: aluModel = x - y;
      3'd2: aluModel = x & y;
      3'd3: aluModel = x | y;
      3'd4: aluModel = x ^ y;
      3'd5: aluModel = ~x;
      3'd6: aluModel = x << 1;
      default: aluModel = y;
    endcase
  endfunction

  assign aluResult = aluModel(aluSelect, aluData1, aluData2);

  // Second ALU presents a new value only two edges after its operands change.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      delay1B <= 8'd0;
      delay2B <= 8'd0;
    end else begin
      delay1B <= aluModel(aluSelectB, aluData1B, aluData2B);
      delay2B <= delay1B;
    end
  end
  assign aluResultB = delay2B;

  alu_share_arbiter #(.DATA_WIDTH(8), .SEL_WIDTH(3), .SETTLE_CYCLES(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(req0), .SEL0(sel0), .A0(a0), .B0(b0),
    .REQ1(req1), .SEL1(sel1), .A1(a1), .B1(b1),
    .ALU_DATA1(aluData1), .ALU_DATA2(aluData2), .ALU_SELECT(aluSelect),
    .ALU_RESULT(aluResult), .RESULT(result), .ZERO(zero),
    .DONE0(done0), .DONE1(done1), .BUSY(busy)
  );

  alu_share_arbiter #(.DATA_WIDTH(8), .SEL_WIDTH(3), .SETTLE_CYCLES(3)) dutSlow (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(reqB), .SEL0(selB), .A0(aB), .B0(bB),
    .REQ1(zeroBit), .SEL1(zeroSel), .A1(zeroByte), .B1(zeroByte),
    .ALU_DATA1(aluData1B), .ALU_DATA2(aluData2B), .ALU_SELECT(aluSelectB),
    .ALU_RESULT(aluResultB), .RESULT(resultB), .ZERO(zeroB),
    .DONE0(done0B), .DONE1(done1B), .BUSY(busyB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [2:0] s0, input logic [7:0] x0, input logic [7:0] y0,
                               input logic r1, input logic [2:0] s1, input logic [7:0] x1, input logic [7:0] y1);
    req0 = r0; sel0 = s0; a0 = x0; b0 = y0;
    req1 = r1; sel1 = s1; a1 = x1; b1 = y1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET_N = 1'b0;
    reqB = 1'b0; selB = 3'd0; aB = 8'd0; bB = 8'd0;
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("reset aluData1", aluData1, 8'h00);
    checkOutput("reset aluSelect", aluSelect, 3'd0);
    checkOutput("reset result", result, 8'h00);
    checkOutput("reset zero", zero, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", {done1, done0}, 2'b00);
    RESET_N = 1'b1;

    // Single OR operation from requester 0.
    applyStimulus(1'b1, 3'd3, 8'hA5, 8'h0F, 1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    checkOutput("or aluData1", aluData1, 8'hA5);
    checkOutput("or aluData2", aluData2, 8'h0F);
    checkOutput("or aluSelect", aluSelect, 3'd3);
    checkOutput("or busy", busy, 1'b1);
    checkOutput("or early done0", done0, 1'b0);
    req0 = 1'b0;
    tick();
    checkOutput("or done", {done1, done0}, 2'b01);
    checkOutput("or result", result, 8'hAF);
    checkOutput("or zero", zero, 1'b0);
    tick();
    checkOutput("or done clear", {done1, done0}, 2'b00);
    checkOutput("or busy clear", busy, 1'b0);

    // Requester 1 AND to zero; it drops REQ and changes B right after grant.
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd2, 8'h0F, 8'hF0);
    tick();
    checkOutput("and aluData2", aluData2, 8'hF0);
    checkOutput("and aluSelect", aluSelect, 3'd2);
    req1 = 1'b0; b1 = 8'hFF;
    tick();
    checkOutput("and done", {done1, done0}, 2'b10);
    checkOutput("and result", result, 8'h00);
    checkOutput("and zero", zero, 1'b1);
    tick();
    checkOutput("and idle", busy, 1'b0);

    // Both requesting continuously: grants alternate 0,1,0,1.
    applyStimulus(1'b1, 3'd0, 8'h01, 8'h02, 1'b1, 3'd4, 8'hFF, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("rr%0d aluSelect", i), aluSelect, (i % 2 == 1) ? 3'd4 : 3'd0);
      checkOutput($sformatf("rr%0d busy", i), busy, 1'b1);
      tick();
      checkOutput($sformatf("rr%0d done", i), {done1, done0}, (i % 2 == 1) ? 2'b10 : 2'b01);
      checkOutput($sformatf("rr%0d result", i), result, (i % 2 == 1) ? 8'hF0 : 8'h03);
      tick();
      checkOutput($sformatf("rr%0d gap", i), {busy, done1, done0}, 3'b000);
    end

    // Requester 0 alone, held high: one operation every three cycles.
    applyStimulus(1'b1, 3'd1, 8'h10, 8'h01, 1'b0, 3'd0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("hold%0d busy", i), busy, 1'b1);
      tick();
      checkOutput($sformatf("hold%0d done", i), {done1, done0}, 2'b01);
      checkOutput($sformatf("hold%0d result", i), result, 8'h0F);
      tick();
      checkOutput($sformatf("hold%0d gap", i), {busy, done0}, 2'b00);
    end

    // Reset while in SETTLE discards the operation.
    tick();
    checkOutput("pre-reset busy", busy, 1'b1);
    RESET_N = 1'b0;
    #1;
    checkOutput("async aluData1", aluData1, 8'h00);
    checkOutput("async aluSelect", aluSelect, 3'd0);
    checkOutput("async result", result, 8'h00);
    checkOutput("async busy", busy, 1'b0);
    applyStimulus(1'b1, 3'd7, 8'h00, 8'h5A, 1'b1, 3'd5, 8'h00, 8'h00);
    tick();
    checkOutput("in-reset done", {done1, done0}, 2'b00);
    RESET_N = 1'b1;
    tick();
    checkOutput("post-reset grant", aluSelect, 3'd7);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    checkOutput("post-reset done", {done1, done0}, 2'b01);
    checkOutput("post-reset result", result, 8'h5A);
    tick();

    // Slow ALU: settle 3 must capture the settled value, not the stale one.
    reqB = 1'b1; selB = 3'd0; aB = 8'h11; bB = 8'h22;
    tick();
    selB = 3'd2; aB = 8'h0F; bB = 8'h3C;
    tick();
    checkOutput("slow1 e1", {busyB, done0B}, 2'b10);
    tick();
    checkOutput("slow1 e2", {busyB, done0B}, 2'b10);
    tick();
    checkOutput("slow1 done", {done1B, done0B}, 2'b01);
    checkOutput("slow1 result", resultB, 8'h33);
    tick();
    checkOutput("slow1 idle", busyB, 1'b0);
    tick();
    checkOutput("slow2 aluSelect", aluSelectB, 3'd2);
    reqB = 1'b0;
    tick();
    checkOutput("slow2 e1", done0B, 1'b0);
    tick();
    checkOutput("slow2 e2", done0B, 1'b0);
    checkOutput("slow2 held result", resultB, 8'h33);
    tick();
    checkOutput("slow2 done", {done1B, done0B}, 2'b01);
    checkOutput("slow2 result", resultB, 8'h0C);
    checkOutput("slow2 zero", zeroB, 1'b0);
    tick();
    checkOutput("slow2 idle", {busyB, done0B}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
